// File: rtl/bcd_sw_pkg.sv
// Shared types and helpers for the BCD stopwatch core: FSM states,
// preset modes and the nibble clamp used when loading presets.
package bcd_sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_t;

  typedef enum logic [1:0] {
    MODE_UP0  = 2'd0,
    MODE_UPLD = 2'd1,
    MODE_DN9  = 2'd2,
    MODE_DNLD = 2'd3
  } sw_mode_t;

  // Any nibble outside the decimal range is forced to 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > 4'd9) ? 4'd9 : nib;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_core_if.sv
// Control, count and display signals of the stopwatch core, bundled so the
// board-level controller (master) and the core (slave) share one port.
interface bcd_stopwatch_core_if #(
  parameter int DIGITS      = 4,
  parameter int LOAD_DIGITS = 2
);
  logic                     reset_req;
  logic                     start_pause;
  logic [1:0]               sel;
  logic [4*LOAD_DIGITS-1:0] load;
  logic                     cnt_tick;
  logic                     scan_tick;
  logic [4*DIGITS-1:0]      count;
  logic                     running;
  logic                     done;
  logic [DIGITS-1:0]        an;
  logic [6:0]               sseg;
  logic                     dp;

  modport master (
    output reset_req, start_pause, sel, load, cnt_tick, scan_tick,
    input  count, running, done, an, sseg, dp
  );

  modport slave (
    input  reset_req, start_pause, sel, load, cnt_tick, scan_tick,
    output count, running, done, an, sseg, dp
  );
endinterface

// File: rtl/bcd_stopwatch_core_digit_cell.sv
// One BCD digit of the stopwatch counter. Loads a preset, or steps up/down
// when enabled and the lower digits pass a carry/borrow in.
module bcd_digit_cell (
  input  logic       c_clk,
  input  logic       C_clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       en,
  input  logic       up,
  input  logic       cin,
  output logic       cout,
  output logic [3:0] digit,
  output logic       is_9,
  output logic       is_0
);
  assign is_9 = (digit == 4'd9);
  assign is_0 = (digit == 4'd0);
  assign cout = cin & (up ? is_9 : is_0);

  // Digit register: preset load has priority, otherwise wrap within 0..9.
  always_ff @(posedge c_clk or posedge C_clr) begin
    if (C_clr) begin
      digit <= 4'd0;
    end else if (ld) begin
      digit <= ld_val;
    end else if (en && cin) begin
      if (up) begin
        digit <= is_9 ? 4'd0 : digit + 4'd1;
      end else begin
        digit <= is_0 ? 4'd9 : digit - 4'd1;
      end
    end
  end
endmodule

// File: rtl/bcd_stopwatch_core_hexto7segment.sv
// Hex digit to seven-segment decoder, active-high segments {g..a}.
module hexto7segment (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // Segment lookup for all sixteen nibble values.
  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  end
endmodule

// File: rtl/bcd_stopwatch_core.sv
// N-digit BCD stopwatch/timer: preset modes, run/pause/done FSM with
// terminal-count detection, and a multiplexed active-low display driver.
module bcd_stopwatch_core
  import bcd_sw_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int LOAD_DIGITS = 2,
  parameter int DP_POS      = 2
) (
  input logic                 c_clk,
  input logic                 C_clr,
  bcd_stopwatch_core_if.slave bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  sw_state_t           state, state_nxt;
  sw_mode_t            mode_q;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] preset, count_q, count_v, near_up, near_dn;
  logic [DIGITS:0]     carry;
  logic [DIGITS-1:0]   is_9, is_0;
  logic                up, terminal, will_term, tick_run, step, ld_en;
  logic [3:0]          digit_sel;
  logic [6:0]          seg_on;

  // The chain is rooted at 1, so the top carry is high exactly when the
  // counter already sits at its terminal value and must not step.
  assign carry[0]  = 1'b1;
  assign up        = (mode_q == MODE_UP0) || (mode_q == MODE_UPLD);
  assign terminal  = up ? (&is_9) : (&is_0);
  assign will_term = (count_q == (up ? near_up : near_dn));
  assign tick_run  = (state == RUN) && bus.cnt_tick && !bus.start_pause && !bus.reset_req;
  assign step      = tick_run && !carry[DIGITS];
  assign ld_en     = (state == IDLE);

  // Preset from the live sel/load, plus the one-step-before-terminal patterns.
  always_comb begin
    preset  = '0;
    near_up = '0;
    near_dn = '0;
    for (int i = 0; i < DIGITS; i++) begin
      near_up[4*i +: 4] = (i == 0) ? 4'd8 : 4'd9;
      near_dn[4*i +: 4] = (i == 0) ? 4'd1 : 4'd0;
    end
    case (sw_mode_t'(bus.sel))
      MODE_DN9: begin
        for (int i = 0; i < DIGITS; i++) preset[4*i +: 4] = 4'd9;
      end
      MODE_UPLD, MODE_DNLD: begin
        for (int i = 0; i < LOAD_DIGITS; i++)
          preset[4*(DIGITS-LOAD_DIGITS+i) +: 4] = bcd_clamp(bus.load[4*i +: 4]);
      end
      default: ;
    endcase
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_cell u_cell (
        .c_clk  (c_clk),
        .C_clr  (C_clr),
        .ld     (ld_en),
        .ld_val (preset[4*g +: 4]),
        .en     (step),
        .up     (up),
        .cin    (carry[g]),
        .cout   (carry[g+1]),
        .digit  (count_q[4*g +: 4]),
        .is_9   (is_9[g]),
        .is_0   (is_0[g])
      );
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge c_clk or posedge C_clr) begin
    if (C_clr) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state; reset_req overrides everything, DONE is sticky.
  always_comb begin
    state_nxt = state;
    if (bus.reset_req) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start_pause) state_nxt = RUN;
        RUN: begin
          if (bus.start_pause)                          state_nxt = PAUSE;
          else if (bus.cnt_tick && (terminal || will_term)) state_nxt = DONE;
        end
        PAUSE:   if (bus.start_pause) state_nxt = RUN;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs; in IDLE the count follows the live preset.
  always_comb begin
    bus.running = (state == RUN);
    bus.done    = (state == DONE);
    count_v     = (state == IDLE) ? preset : count_q;
    bus.count   = count_v;
  end

  // Mode is captured only on the start that leaves IDLE.
  always_ff @(posedge c_clk or posedge C_clr) begin
    if (C_clr) begin
      mode_q <= MODE_UP0;
    end else if ((state == IDLE) && bus.start_pause && !bus.reset_req) begin
      mode_q <= sw_mode_t'(bus.sel);
    end
  end

  // Scan index walks 0, DIGITS-1, ..., 1, 0 on each scan tick.
  always_ff @(posedge c_clk or posedge C_clr) begin
    if (C_clr) begin
      idx <= '0;
    end else if (bus.scan_tick) begin
      idx <= (idx == '0) ? IDX_W'(DIGITS - 1) : idx - 1'b1;
    end
  end

  hexto7segment u_dec (
    .hex (digit_sel),
    .seg (seg_on)
  );

  // Active-low display drive for the selected digit.
  always_comb begin
    digit_sel = count_v[4*idx +: 4];
    bus.an    = ~(DIGITS'(1) << idx);
    bus.sseg  = ~seg_on;
    bus.dp    = (int'(idx) == DP_POS) ? 1'b0 : 1'b1;
  end
endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Randomized scoreboard bench for bcd_stopwatch_core against a decimal
// integer model of the stopwatch.
module tb_bcd_stopwatch_core;
  localparam int D    = 4;
  localparam int LD   = 2;
  localparam int DP   = 2;
  localparam int MAXV = 9999;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  localparam logic [6:0] SEG_ON [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct packed {
    logic [4*D-1:0] count;
    logic           running;
    logic           done;
    logic [D-1:0]   an;
    logic [6:0]     sseg;
    logic           dp;
  } exp_t;

  logic c_clk = 1'b0;
  logic C_clr = 1'b1;

  int assertCount = 0;
  int failCount   = 0;

  int m_state, m_val, m_mode, m_idx;
  exp_t expQ [$];

  bcd_stopwatch_core_if #(.DIGITS(D), .LOAD_DIGITS(LD)) bus ();

  bcd_stopwatch_core #(.DIGITS(D), .LOAD_DIGITS(LD), .DP_POS(DP)) dut (
    .c_clk (c_clk),
    .C_clr (C_clr),
    .bus   (bus)
  );

  always #5 c_clk = ~c_clk;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*D-1:0] toBcd(input int v);
    logic [4*D-1:0] b = '0;
    for (int i = 0; i < D; i++) b[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return b;
  endfunction

  function automatic int presetVal(input logic [1:0] s, input logic [4*LD-1:0] ld);
    int v = 0;
    int nib;
    if (s == 2'd0) return 0;
    if (s == 2'd2) return MAXV;
    for (int i = 0; i < LD; i++) begin
      nib = int'(ld[4*i +: 4]);
      if (nib > 9) nib = 9;
      v = v + nib * pow10(D - LD + i);
    end
    return v;
  endfunction

  function automatic int termVal();
    return (m_mode < 2) ? MAXV : 0;
  endfunction

  task automatic resetModel();
    m_state = S_IDLE;
    m_val   = 0;
    m_mode  = 0;
    m_idx   = 0;
  endtask

  task automatic pushExpected(input logic [1:0] s, input logic [4*LD-1:0] ld);
    exp_t e;
    int shown;
    int dig;
    shown     = (m_state == S_IDLE) ? presetVal(s, ld) : m_val;
    dig       = (shown / pow10(m_idx)) % 10;
    e.count   = toBcd(shown);
    e.running = (m_state == S_RUN);
    e.done    = (m_state == S_DONE);
    e.an      = ~(D'(1) << m_idx);
    e.sseg    = ~SEG_ON[dig];
    e.dp      = (m_idx == DP) ? 1'b0 : 1'b1;
    expQ.push_back(e);
  endtask

  task automatic stepModel(input logic clr, rr, sp, tick, scan,
                           input logic [1:0] s, input logic [4*LD-1:0] ld);
    if (clr) begin
      resetModel();
      return;
    end
    if (scan) m_idx = (m_idx == 0) ? D - 1 : m_idx - 1;
    if (rr) begin
      m_state = S_IDLE;
    end else begin
      case (m_state)
        S_IDLE: begin
          m_val = presetVal(s, ld);
          if (sp) begin
            m_mode  = int'(s);
            m_state = S_RUN;
          end
        end
        S_RUN: begin
          if (sp) begin
            m_state = S_PAUSE;
          end else if (tick) begin
            if (m_val == termVal()) begin
              m_state = S_DONE;
            end else begin
              m_val = m_val + ((m_mode < 2) ? 1 : -1);
              if (m_val == termVal()) m_state = S_DONE;
            end
          end
        end
        S_PAUSE: if (sp) m_state = S_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic clr, rr, sp, tick, scan,
                               input logic [1:0] s, input logic [4*LD-1:0] ld);
    @(posedge c_clk);
    #1;
    C_clr           = clr;
    bus.reset_req   = rr;
    bus.start_pause = sp;
    bus.cnt_tick    = tick;
    bus.scan_tick   = scan;
    bus.sel         = s;
    bus.load        = ld;
    if (clr) resetModel();
    pushExpected(s, ld);
    stepModel(clr, rr, sp, tick, scan, s, ld);
  endtask

  task automatic runTicks(input int n, input logic [1:0] s, input logic [4*LD-1:0] ld);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 2) == 0), s, ld);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    assertCount++;
    if (act !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("count",   32'(bus.count),   32'(e.count));
    cmp("running", 32'(bus.running), 32'(e.running));
    cmp("done",    32'(bus.done),    32'(e.done));
    cmp("an",      32'(bus.an),      32'(e.an));
    cmp("sseg",    32'(bus.sseg),    32'(e.sseg));
    cmp("dp",      32'(bus.dp),      32'(e.dp));
  endtask

  // Monitor: drains the scoreboard mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge c_clk);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    bus.reset_req   = 1'b0;
    bus.start_pause = 1'b0;
    bus.cnt_tick    = 1'b0;
    bus.scan_tick   = 1'b0;
    bus.sel         = 2'd0;
    bus.load        = '0;
    resetModel();

    // Reset values with a few live presets
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'h47);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

    // Full up count from zero, terminal edge and hold
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    runTicks(10003, 2'd2, 8'h55);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

    // Down from loaded 12 to zero
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h12);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 8'h12);
    runTicks(1202, 2'd3, 8'h12);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'h3F);

    // Clamped preset shown in IDLE
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8'h3F);

    // Pause collision, resume, sel change mid-run, then reset_req
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    runTicks(5, 2'd0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    runTicks(3, 2'd0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    runTicks(4, 2'd2, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 8'h00);

    // Start already at terminal value
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 8'h00);
    runTicks(3, 2'd3, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

    // Display scan order with an asynchronous clear mid-sequence
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'h98);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h98);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      applyStimulus(1'($urandom_range(0, 499) == 0),
                    1'($urandom_range(0, 199) == 0),
                    1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 2) == 0),
                    2'($urandom_range(0, 3)),
                    8'($urandom));

    // Clear mid-count
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'h99);
    runTicks(4, 2'd1, 8'h99);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 8'h00);

    @(negedge c_clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/bcd_stopwatch_core.md
# bcd_stopwatch_core

Parametrised BCD stopwatch/timer core: an N-digit decimal up/down counter with four preset modes, a run/pause/done control FSM and a multiplexed active-low seven-segment display driver. The whole block runs in a single clock domain. Count and display-scan rates come from enable ticks generated upstream by the board-level prescaler. Successor to the fixed 4-digit stopwatch: it adds digit-count parametrisation, terminal-count detection, a DONE state and sel latching at start.

## Interface
- DIGITS, 4: number of BCD digits (2..8).
- LOAD_DIGITS, 2: number of most-significant digits set from `load` (1..DIGITS).
- DP_POS, 2: digit index whose decimal point is lit (0 = least significant).

Ports:
- c_clk  in  1  system clock; all state on rising edge.
- C_clr  in  1  reset, asynchronous, active-high.
- reset_req  in  1  synchronous clear request, level; return to IDLE.
- start_pause  in  1  single-cycle pulse; start/pause/resume.
- sel  in  2  mode: 0 up from 0; 1 up from load; 2 down from all-9; 3 down from load.
- load  in  4*LOAD_DIGITS  BCD preset for the top digits.
- cnt_tick  in  1  count enable pulse.
- scan_tick  in  1  display scan enable pulse.
- count  out  4*DIGITS  current BCD value.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- an  out  DIGITS  digit enables, active-low one-hot.
- sseg  out  7  segments {g..a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- FSM states: IDLE, RUN, PAUSE, DONE. Reset and reset_req go to IDLE. reset_req has priority over every other event.
- IDLE: `count` tracks the preset of the live `sel` and `load` every cycle.
  - Mode 0: all zero. Mode 2: all 9.
  - Modes 1 and 3: top LOAD_DIGITS taken from `load`, remaining digits 0.
  - Any load nibble greater than 9 is clamped to 9.
- IDLE + start_pause: go to RUN and latch `sel` into mode_q. Changes to `sel` while not in IDLE are ignored.
- RUN + start_pause: go to PAUSE. PAUSE + start_pause: go to RUN. A count value is held in PAUSE.
- RUN + cnt_tick: BCD increment (modes 0/1) or decrement (modes 2/3) with ripple carry/borrow across all digits. Each digit stays within 0..9.
- Terminal value is all-9 for up modes and all-0 for down modes.
  - On the edge where `count` becomes terminal, the FSM enters DONE.
  - If RUN is entered with `count` already terminal, the next cnt_tick moves the FSM to DONE and leaves `count` unchanged. The counter never wraps.
- DONE: `count` is frozen and start_pause is ignored. Only reset_req or C_clr leave DONE.
- start_pause and cnt_tick in the same cycle in RUN: the FSM pauses and the tick is dropped.
- Display: scan index idx advances on scan_tick in the order 0 → DIGITS-1 → DIGITS-2 … → 1 → 0.
  - an = ~(1<<idx).
  - sseg = decode(digit idx); decoding is active in every state.
  - dp = 0 when idx == DP_POS, else 1.

## Timing
- Values on reset: state IDLE; idx 0; mode_q 0; count = preset of current sel/load; running 0; done 0; an = ~1; sseg = decode(count[3:0]); dp = (DP_POS==0 ? 0 : 1).
- `count`, running and done are registered and change 1 cycle after the triggering pulse.
- an, sseg and dp are combinational from idx and count. A new digit appears 1 cycle after scan_tick.
- C_clr asserted mid-count returns to the reset values immediately, without waiting for a clock edge.
- Deasserting C_clr restarts operation from IDLE.

## Structure
- Package bcd_sw_pkg: state enum (IDLE, RUN, PAUSE, DONE), mode encodings (MODE_UP0, MODE_UPLD, MODE_DN9, MODE_DNLD) and the BCD clamp function.
- Sub-module bcd_digit_cell: one digit with en, up, carry/borrow in/out and is_9/is_0 flags. Instantiated DIGITS times in a generate loop.
- Existing hexto7segment decodes the selected digit; its output is inverted if needed to drive sseg active-low.

## Test plan
- DIGITS=4, sel=0, start, 10000 cnt_ticks → count goes 0000→9999; done asserts on the 9999 edge; further ticks hold 9999.
- sel=3, load=8'h12, start, 1 tick → count 1199; after 1199 more ticks → count 0000 and done=1.
- sel=1, load=8'h3F → IDLE count = 3900 (nibble F clamped to 9).
- In RUN, apply start_pause and cnt_tick together → count unchanged, state PAUSE; after resume, the next tick increments.
- Change sel from 0 to 2 mid-RUN → count keeps incrementing; reset_req → count 9999, state IDLE.
- DIGITS=6, DP_POS=2, 7 scan_ticks → an sequence ~1, ~32, ~16, ~8, ~4, ~2, ~1, ~32; dp=0 only while an=~4; assert C_clr mid-sequence → an=~1 immediately.
